// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: order encodings, length/tap table, seeding and the
// multi-bit LFSR advance used by both the generator and the checker.
package prbs_pkg;

  localparam int ST_W = 31;

  typedef enum logic [2:0] {
    ORD_PRBS7  = 3'd0,
    ORD_PRBS9  = 3'd1,
    ORD_PRBS15 = 3'd2,
    ORD_PRBS23 = 3'd3,
    ORD_PRBS31 = 3'd4
  } order_e;

  typedef enum logic {
    CHK_SEARCH,
    CHK_LOCKED
  } chk_state_e;

  typedef struct packed {
    logic [ST_W-1:0] state;
    logic [31:0]     out_word;
    logic [31:0]     fb_word;
  } step_t;

  function automatic logic [4:0] order_len(input logic [2:0] order);
    case (order)
      ORD_PRBS7:  return 5'd7;
      ORD_PRBS9:  return 5'd9;
      ORD_PRBS15: return 5'd15;
      ORD_PRBS23: return 5'd23;
      default:    return 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] order_tap(input logic [2:0] order);
    case (order)
      ORD_PRBS7:  return 5'd6;
      ORD_PRBS9:  return 5'd5;
      ORD_PRBS15: return 5'd14;
      ORD_PRBS23: return 5'd18;
      default:    return 5'd28;
    endcase
  endfunction

  function automatic logic [ST_W-1:0] order_mask(input logic [2:0] order);
    return ST_W'((32'd1 << order_len(order)) - 32'd1);
  endfunction

  // An all-zero seed slice would lock the LFSR up, so it is replaced by 1.
  function automatic logic [ST_W-1:0] order_seed(input logic [2:0] order,
                                                 input logic [ST_W-1:0] seed);
    logic [ST_W-1:0] s;
    s = seed & order_mask(order);
    return (s == '0) ? ST_W'(1) : s;
  endfunction

  // First emitted bit ends up in bit steps-1 of out_word; fb_word collects the
  // feedback bits, which continue the sequence N bits after the emitted ones.
  function automatic step_t prbs_advance(input logic [ST_W-1:0] state,
                                         input logic [2:0]      order,
                                         input logic [ST_W-1:0] mask,
                                         input int              steps);
    step_t    r;
    logic [4:0] n;
    logic [4:0] t;
    logic     msb;
    logic     fb;
    n = order_len(order);
    t = order_tap(order);
    r.state    = state & mask;
    r.out_word = '0;
    r.fb_word  = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < steps) begin
        msb        = r.state[n - 5'd1];
        fb         = msb ^ r.state[t - 5'd1];
        r.out_word = {r.out_word[30:0], msb};
        r.fb_word  = {r.fb_word[30:0], fb};
        r.state    = {r.state[ST_W-2:0], fb} & mask;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational NB_DATA-step LFSR advance; yields the next state, the emitted
// word and the feedback word.
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int NB_DATA = 8
) (
  input  logic [ST_W-1:0]    state,
  input  logic [2:0]         order,
  input  logic [ST_W-1:0]    mask,
  output logic [ST_W-1:0]    next_state,
  output logic [NB_DATA-1:0] out_word,
  output logic [NB_DATA-1:0] fb_word
);

  step_t r;
  logic  unused_words;

  always_comb begin
    r          = prbs_advance(state, order, mask, NB_DATA);
    next_state = r.state;
    out_word   = r.out_word[NB_DATA-1:0];
    fb_word    = r.fb_word[NB_DATA-1:0];
  end

  assign unused_words = ^{r.out_word, r.fb_word};

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS7..31 generator with single-bit error injection, plus a self-synchronising
// checker with lock detection and a saturating bit-error counter.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int          NB_DATA    = 8,
  parameter logic [30:0] SEED       = 31'h1AA,
  parameter int          LOCK_WORDS = 4,
  parameter int          LOSS_WORDS = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [2:0]         i_order,
  input  logic               i_enable,
  input  logic               i_inject,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_clr_cnt,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_lock,
  output logic               o_err,
  output logic [31:0]        o_err_count
);

  localparam int CNT_MAX = (LOCK_WORDS > LOSS_WORDS) ? LOCK_WORDS : LOSS_WORDS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EW      = $clog2(NB_DATA + 1);
  localparam logic [CNT_W-1:0]   LOCK_N  = CNT_W'(LOCK_WORDS);
  localparam logic [CNT_W-1:0]   LOSS_N  = CNT_W'(LOSS_WORDS);
  localparam logic [NB_DATA-1:0] MSB_BIT = NB_DATA'(1) << (NB_DATA - 1);

  function automatic logic [EW-1:0] popcount(input logic [NB_DATA-1:0] v);
    logic [EW-1:0] c;
    c = '0;
    for (int i = 0; i < NB_DATA; i++) c = c + EW'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [EW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [2:0]         order_q;
  logic               order_chg;
  logic [ST_W-1:0]    mask_q;
  logic [ST_W-1:0]    gen_state;
  logic [ST_W-1:0]    gen_next;
  logic [NB_DATA-1:0] gen_word;
  logic [NB_DATA-1:0] unused_gen_fb;
  logic               inject_pend;

  assign order_chg = (i_order != order_q);
  assign mask_q    = order_mask(order_q);

  prbs_lfsr_step #(.NB_DATA(NB_DATA)) u_gen_step (
    .state      (gen_state),
    .order      (order_q),
    .mask       (mask_q),
    .next_state (gen_next),
    .out_word   (gen_word),
    .fb_word    (unused_gen_fb)
  );

  // Generator stage: registered word, injection flips the oldest bit only.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      order_q     <= i_order;
      gen_state   <= order_seed(i_order, SEED);
      inject_pend <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
    end else if (order_chg) begin
      order_q     <= i_order;
      gen_state   <= order_seed(i_order, SEED);
      inject_pend <= 1'b0;
      o_valid     <= 1'b0;
    end else if (i_enable) begin
      gen_state   <= gen_next;
      o_data      <= gen_word ^ ((inject_pend | i_inject) ? MSB_BIT : '0);
      o_valid     <= 1'b1;
      inject_pend <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_inject) inject_pend <= 1'b1;
    end
  end

  // Checker state holds the last N bits seen (newest in bit 0), so the next
  // received bits are the LFSR feedback bits, not the emitted ones.
  chk_state_e         fsm, fsm_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic [ST_W-1:0]    ck_state, ck_nx, ck_adv, ck_shift;
  logic [NB_DATA-1:0] ck_pred;
  logic [NB_DATA-1:0] unused_ck_out;
  logic [EW-1:0]      bit_errs;
  logic [EW-1:0]      add_nx;
  logic               word_bad;
  logic               err_nx;
  logic [31:0]        count_nx;

  prbs_lfsr_step #(.NB_DATA(NB_DATA)) u_chk_step (
    .state      (ck_state),
    .order      (order_q),
    .mask       (mask_q),
    .next_state (ck_adv),
    .out_word   (unused_ck_out),
    .fb_word    (ck_pred)
  );

  assign ck_shift = ST_W'({ck_state, i_rx_data}) & mask_q;
  assign bit_errs = popcount(i_rx_data ^ ck_pred);
  assign word_bad = (32'(bit_errs) << 1) > 32'(NB_DATA);
  assign cnt_inc  = cnt + CNT_W'(1);

  always_comb begin
    fsm_nx = fsm;
    cnt_nx = cnt;
    ck_nx  = ck_state;
    err_nx = 1'b0;
    add_nx = '0;
    if (order_chg) begin
      fsm_nx = CHK_SEARCH;
      cnt_nx = '0;
    end else if (i_rx_valid) begin
      case (fsm)
        CHK_SEARCH: begin
          ck_nx = ck_shift;
          if (i_rx_data == ck_pred) begin
            if (cnt_inc == LOCK_N) begin
              fsm_nx = CHK_LOCKED;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        CHK_LOCKED: begin
          ck_nx  = ck_adv;
          err_nx = (bit_errs != '0);
          add_nx = bit_errs;
          if (word_bad) begin
            if (cnt_inc == LOSS_N) begin
              fsm_nx = CHK_SEARCH;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        default: begin
          fsm_nx = CHK_SEARCH;
          cnt_nx = '0;
        end
      endcase
    end
    count_nx = i_clr_cnt ? 32'd0 : sat_add(o_err_count, add_nx);
  end

  // Checker stage: lock, error pulse and count reflect the word just consumed.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      fsm         <= CHK_SEARCH;
      cnt         <= '0;
      ck_state    <= '0;
      o_lock      <= 1'b0;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else begin
      fsm         <= fsm_nx;
      cnt         <= cnt_nx;
      ck_state    <= ck_nx;
      o_lock      <= (fsm_nx == CHK_LOCKED);
      o_err       <= err_nx;
      o_err_count <= count_nx;
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: an 8-bit instance in loopback and a 1-bit
// instance compared against a serial LFSR model.
module tb_prbs_gen_chk;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst8 = 1'b1, en8 = 1'b0, inj8 = 1'b0, clr8 = 1'b0, inv8 = 1'b0;
  logic [2:0] ord8 = 3'd1;
  logic [7:0] data8, rx8;
  logic       valid8, lock8, err8;
  logic [31:0] cnt8;

  assign rx8 = data8 ^ {8{inv8}};

  prbs_gen_chk #(.NB_DATA(8), .SEED(31'h1AA), .LOCK_WORDS(4), .LOSS_WORDS(4)) u8 (
    .clock(clock), .i_reset(rst8), .i_order(ord8), .i_enable(en8), .i_inject(inj8),
    .i_rx_data(rx8), .i_rx_valid(valid8), .i_clr_cnt(clr8),
    .o_data(data8), .o_valid(valid8), .o_lock(lock8), .o_err(err8), .o_err_count(cnt8)
  );

  logic       rst1 = 1'b1, en1 = 1'b0;
  logic [2:0] ord1 = 3'd0;
  logic [0:0] data1;
  logic       valid1, lock1, err1;
  logic [31:0] cnt1;

  prbs_gen_chk #(.NB_DATA(1), .SEED(31'h1AA), .LOCK_WORDS(4), .LOSS_WORDS(4)) u1 (
    .clock(clock), .i_reset(rst1), .i_order(ord1), .i_enable(en1), .i_inject(1'b0),
    .i_rx_data(data1), .i_rx_valid(valid1), .i_clr_cnt(1'b0),
    .o_data(data1), .o_valid(valid1), .o_lock(lock1), .o_err(err1), .o_err_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts valid words entering the checker until lock, bounded by budget.
  task automatic wait_lock(input int budget, output int words);
    words = 0;
    for (int i = 0; i < budget && !lock8; i++) begin
      if (valid8) words++;
      tick();
    end
  endtask

  task automatic run_serial(input logic [2:0] ord, input int n, input int t, input string tag);
    logic [30:0] s, mask;
    logic        b;
    logic        hist[$];
    int period, nbits, mism, zrun, zmax, rep;
    period = (1 << n) - 1;
    nbits  = 2 * period + 10;
    mism = 0; zrun = 0; zmax = 0; rep = 0;
    mask = (31'd1 << n) - 31'd1;
    s = 31'h1AA & mask;
    if (s == '0) s = 31'd1;
    ord1 = ord; rst1 = 1'b1;
    tick(); tick();
    rst1 = 1'b0; en1 = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      tick();
      b = s[n-1];
      s = {s[29:0], s[n-1] ^ s[t-1]} & mask;
      if (!valid1 || data1[0] !== b) mism++;
      zrun = data1[0] ? 0 : zrun + 1;
      if (zrun > zmax) zmax = zrun;
      hist.push_back(data1[0]);
    end
    en1 = 1'b0;
    for (int i = period; i < nbits; i++) if (hist[i] !== hist[i-period]) rep++;
    check({tag, "_vs_model"}, mism, 0);
    check({tag, "_zero_run_lt_n"}, zmax < n, 1);
    check({tag, "_period"}, rep, 0);
  endtask

  int words, drops, pulses;

  initial begin
    // reset state
    tick(); tick();
    check("rst_data", data8, 0);
    check("rst_valid", valid8, 0);
    check("rst_lock", lock8, 0);
    check("rst_err", err8, 0);
    check("rst_count", cnt8, 0);

    // PRBS9 first words and enable hold
    rst8 = 1'b0; en8 = 1'b1;
    tick();
    check("word1_valid", valid8, 1);
    check("word1", data8, 8'hD5);
    tick();
    check("word2", data8, 8'h40);
    en8 = 1'b0;
    tick();
    check("hold_valid", valid8, 0);
    check("hold_data", data8, 8'h40);
    en8 = 1'b1;
    wait_lock(30, words);
    check("lock_prbs9", lock8, 1);
    check("lock_words_le6", (words + 2) <= 6, 1);

    // long clean loopback
    drops = 0; pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (!lock8) drops++;
      if (err8) pulses++;
    end
    check("clean_count", cnt8, 0);
    check("clean_drops", drops, 0);
    check("clean_err_pulses", pulses, 0);

    // three injected single-bit errors
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      inj8 = 1'b1;
      tick();
      inj8 = 1'b0;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (err8) pulses++;
      end
    end
    check("inject_pulses", pulses, 3);
    check("inject_count", cnt8, 3);
    check("inject_lock", lock8, 1);

    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    check("clr_alone", cnt8, 0);

    inj8 = 1'b1;
    tick();
    inj8 = 1'b0; clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    check("clr_err_pulse", err8, 1);
    check("clr_wins", cnt8, 0);
    tick();
    check("err_one_cycle", err8, 0);

    // four inverted words drop lock, clean stream relocks
    inv8 = 1'b1;
    tick(); tick(); tick();
    check("inv3_lock", lock8, 1);
    tick();
    check("inv4_lock", lock8, 0);
    inv8 = 1'b0;
    check("inv_count", cnt8, 32);
    wait_lock(30, words);
    check("relock", lock8, 1);
    check("relock_words_le6", words <= 6, 1);
    check("relock_count", cnt8, 32);

    // order change to PRBS31
    ord8 = 3'd4;
    tick();
    check("order_chg_lock", lock8, 0);
    check("order_chg_count", cnt8, 32);
    wait_lock(40, words);
    check("lock_prbs31", lock8, 1);
    check("lock31_words_le8", words <= 8, 1);

    // saturation
    force u8.o_err_count = 32'hFFFF_FFFD;
    @(negedge clock);
    release u8.o_err_count;
    inv8 = 1'b1;
    tick();
    check("sat_first", cnt8, 32'hFFFF_FFFF);
    tick();
    check("sat_hold", cnt8, 32'hFFFF_FFFF);
    inv8 = 1'b0;
    tick(); tick(); tick();
    check("sat_lock", lock8, 1);
    check("sat_final", cnt8, 32'hFFFF_FFFF);

    // 1-bit instance sequences
    run_serial(3'd0, 7, 6, "prbs7_nb1");
    run_serial(3'd1, 9, 5, "prbs9_nb1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
